// File: rtl/rsa_control_if.sv
// Sequencer-side bundle for rsa_control: key inputs, start strobes, message path
// and the two finish flags.
interface rsa_control_if #(parameter int WIDTH = 128);
  logic [WIDTH-1:0]   p;
  logic [WIDTH-1:0]   q;
  logic               reset_inverter;
  logic               reset_mod_exp;
  logic               encrypt_decrypt;
  logic [2*WIDTH-1:0] msg_in;
  logic               inverter_finish;
  logic [2*WIDTH-1:0] msg_out;
  logic               mod_exp_finish;

  modport master (
    output p, q, reset_inverter, reset_mod_exp, encrypt_decrypt, msg_in,
    input  inverter_finish, msg_out, mod_exp_finish
  );

  modport slave (
    input  p, q, reset_inverter, reset_mod_exp, encrypt_decrypt, msg_in,
    output inverter_finish, msg_out, mod_exp_finish
  );
endinterface

// File: rtl/rsa_control.sv
// Iterative RSA engine: derives n, phi and d = 65537^-1 mod phi by extended Euclid,
// then computes msg^e or msg^d mod n with bit-serial square-and-multiply.
module rsa_control #(
    parameter int WIDTH = 128
) (
    input logic        clk,
    input logic        reset_n,
    rsa_control_if.slave bus
);
    localparam int NW = 2 * WIDTH;
    localparam int KW = NW + 1;
    localparam int RW = NW + 2;
    localparam int CW = $clog2(RW) + 1;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] INV_SETUP = 3'd1;
    localparam logic [2:0] INV_LOOP  = 3'd2;
    localparam logic [2:0] INV_DONE  = 3'd3;
    localparam logic [2:0] EXP_SETUP = 3'd4;
    localparam logic [2:0] EXP_LOOP  = 3'd5;
    localparam logic [2:0] EXP_DONE  = 3'd6;

    localparam logic [1:0] OP_NORM = 2'd0;
    localparam logic [1:0] OP_NEXT = 2'd1;
    localparam logic [1:0] OP_SQR  = 2'd2;
    localparam logic [1:0] OP_MUL  = 2'd3;

    localparam logic [KW-1:0] E_PUB = KW'(65537);

    logic [2:0]    state;
    logic [1:0]    op;
    logic [NW-1:0] n, phi, d;
    logic [RW-1:0] r0, r1, t0, t1, acc, dq, drem;
    logic [CW-1:0] cnt;
    logic [NW-1:0] mm_a, mm_b, m, res;
    logic [RW-1:0] mm_acc;
    logic [CW-1:0] mm_cnt;
    logic [KW-1:0] kreg;
    logic [CW-1:0] kcnt;

    // Restoring division of r0 by r1; the quotient bits also accumulate q*t1 for the
    // Bezout coefficient, so no multiplier is needed in the Euclid step.
    logic [RW-1:0] rem_sh, rem_nx, acc_nx, t_new;
    logic          ge, div_last;
    logic [NW-1:0] d_fin;

    assign rem_sh   = (drem << 1) | RW'(dq[RW-1]);
    assign ge       = rem_sh >= r1;
    assign rem_nx   = ge ? rem_sh - r1 : rem_sh;
    assign acc_nx   = (acc << 1) + (ge ? t1 : '0);
    assign t_new    = t0 - acc_nx;
    assign div_last = cnt == CW'(RW - 1);
    assign d_fin    = t0[RW-1] ? t0[NW-1:0] + phi : t0[NW-1:0];

    // Interleaved shift-add modular multiply: acc < n and a <= n keep 2*acc+a < 3n.
    logic [RW-1:0] n_ext, mm_sum, mm_r1, mm_nx;
    logic [NW-1:0] mm_res;
    logic          mm_last;

    assign n_ext   = {2'b00, n};
    assign mm_sum  = (mm_acc << 1) + (mm_b[NW-1] ? {2'b00, mm_a} : '0);
    assign mm_r1   = (mm_sum >= n_ext) ? mm_sum - n_ext : mm_sum;
    assign mm_nx   = (mm_r1 >= n_ext) ? mm_r1 - n_ext : mm_r1;
    assign mm_res  = mm_nx[NW-1:0];
    assign mm_last = mm_cnt == CW'(NW - 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state               <= IDLE;
            op                  <= OP_NORM;
            n                   <= '0;
            phi                 <= '0;
            d                   <= '0;
            r0                  <= '0;
            r1                  <= '0;
            t0                  <= '0;
            t1                  <= '0;
            acc                 <= '0;
            dq                  <= '0;
            drem                <= '0;
            cnt                 <= '0;
            mm_a                <= '0;
            mm_b                <= '0;
            mm_acc              <= '0;
            mm_cnt              <= '0;
            m                   <= '0;
            res                 <= '0;
            kreg                <= '0;
            kcnt                <= '0;
            bus.inverter_finish <= 1'b0;
            bus.mod_exp_finish  <= 1'b0;
            bus.msg_out         <= '0;
        end else if (bus.reset_inverter) begin
            bus.inverter_finish <= 1'b0;
            bus.mod_exp_finish  <= 1'b0;
            n     <= NW'(bus.p) * NW'(bus.q);
            phi   <= NW'(bus.p - WIDTH'(1)) * NW'(bus.q - WIDTH'(1));
            d     <= '0;
            state <= INV_SETUP;
        end else if (bus.reset_mod_exp && bus.inverter_finish) begin
            bus.mod_exp_finish <= 1'b0;
            mm_a   <= NW'(1);
            mm_b   <= bus.msg_in;
            mm_acc <= '0;
            mm_cnt <= '0;
            kreg   <= bus.encrypt_decrypt ? {1'b0, d} : E_PUB;
            kcnt   <= CW'(KW);
            state  <= EXP_SETUP;
        end else begin
            case (state)
                INV_SETUP: begin
                    r0    <= {2'b00, phi};
                    r1    <= RW'(65537);
                    t0    <= '0;
                    t1    <= RW'(1);
                    dq    <= {2'b00, phi};
                    drem  <= '0;
                    acc   <= '0;
                    cnt   <= '0;
                    state <= INV_LOOP;
                end
                INV_LOOP: begin
                    if (r1 == '0) begin
                        d                   <= (r0 == RW'(1)) ? d_fin : '0;
                        bus.inverter_finish <= 1'b1;
                        state               <= INV_DONE;
                    end else if (div_last) begin
                        r0   <= r1;
                        r1   <= rem_nx;
                        t0   <= t1;
                        t1   <= t_new;
                        dq   <= r1;
                        drem <= '0;
                        acc  <= '0;
                        cnt  <= '0;
                    end else begin
                        dq   <= {dq[RW-2:0], ge};
                        drem <= rem_nx;
                        acc  <= acc_nx;
                        cnt  <= cnt + 1'b1;
                    end
                end
                EXP_SETUP: begin
                    mm_acc <= mm_nx;
                    mm_b   <= mm_b << 1;
                    mm_cnt <= mm_cnt + 1'b1;
                    if (mm_last) begin
                        m     <= mm_res;
                        res   <= mm_res;
                        op    <= OP_NORM;
                        state <= EXP_LOOP;
                    end
                end
                EXP_LOOP: begin
                    case (op)
                        OP_NORM: begin
                            if (kcnt == '0) begin
                                bus.msg_out        <= (n == NW'(1)) ? '0 : NW'(1);
                                bus.mod_exp_finish <= 1'b1;
                                state              <= EXP_DONE;
                            end else begin
                                kreg <= kreg << 1;
                                kcnt <= kcnt - 1'b1;
                                if (kreg[KW-1]) op <= OP_NEXT;
                            end
                        end
                        OP_NEXT: begin
                            if (kcnt == '0) begin
                                bus.msg_out        <= res;
                                bus.mod_exp_finish <= 1'b1;
                                state              <= EXP_DONE;
                            end else begin
                                mm_a   <= res;
                                mm_b   <= res;
                                mm_acc <= '0;
                                mm_cnt <= '0;
                                op     <= OP_SQR;
                            end
                        end
                        default: begin
                            mm_acc <= mm_nx;
                            mm_b   <= mm_b << 1;
                            mm_cnt <= mm_cnt + 1'b1;
                            if (mm_last) begin
                                res <= mm_res;
                                op  <= OP_NEXT;
                                if (op == OP_SQR) begin
                                    kreg <= kreg << 1;
                                    kcnt <= kcnt - 1'b1;
                                    if (kreg[KW-1]) begin
                                        mm_a   <= m;
                                        mm_b   <= mm_res;
                                        mm_acc <= '0;
                                        mm_cnt <= '0;
                                        op     <= OP_MUL;
                                    end
                                end
                            end
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rsa_control.sv
// Bench for rsa_control at WIDTH=8: table of key/message vectors checked through a
// result scoreboard, plus abort, ignore and reset sequences.
module tb_rsa_control;
    localparam int W  = 8;
    localparam int NW = 2 * W;
    localparam int TMO = 5000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    rsa_control_if #(.WIDTH(W)) bus ();
    rsa_control #(.WIDTH(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    typedef struct {
        int p;
        int q;
        bit ed;
        int msg;
        int exp;   // -1: derive from the bench model
    } vec_t;

    vec_t   vt[10];
    int     n_checks = 0;
    int     n_fail   = 0;
    longint sb_q[$];
    bit     prev_fin = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint modpow(input longint b, input longint k, input longint n);
        longint r = 1 % n;
        longint x = b % n;
        while (k > 0) begin
            if (k[0]) r = (r * x) % n;
            x = (x * x) % n;
            k = k >> 1;
        end
        return r;
    endfunction

    function automatic longint modinv(input longint phi);
        if (phi <= 1) return 0;
        for (longint i = 1; i < phi; i++)
            if ((65537 * i) % phi == 1) return i;
        return 0;
    endfunction

    // Scoreboard: one expected result per completed exponentiation.
    always @(negedge clk) begin
        if (reset_n && bus.mod_exp_finish && !prev_fin) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got %0d, expected no completion", bus.msg_out);
            end else begin
                check("msg_out", longint'(bus.msg_out), sb_q.pop_front());
            end
        end
        prev_fin = bus.mod_exp_finish;
    end

    task automatic pulse_inv(input int p, input int q);
        @(negedge clk);
        bus.p = W'(p);
        bus.q = W'(q);
        bus.reset_inverter = 1'b1;
        @(negedge clk);
        bus.reset_inverter = 1'b0;
        bus.p = W'($urandom);
        bus.q = W'($urandom);
    endtask

    task automatic pulse_exp(input bit ed, input int msg);
        @(negedge clk);
        bus.msg_in = NW'(msg);
        bus.encrypt_decrypt = ed;
        bus.reset_mod_exp = 1'b1;
        @(negedge clk);
        bus.reset_mod_exp = 1'b0;
        bus.msg_in = NW'($urandom);
        bus.encrypt_decrypt = 1'($urandom);
    endtask

    task automatic wait_flag(input bit which, input string name);
        int cyc = 0;
        while (((which ? bus.mod_exp_finish : bus.inverter_finish) !== 1'b1) && cyc < TMO) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (cyc >= TMO) begin
            n_fail++;
            $display("FAIL %s: flag still low after %0d cycles, expected high", name, cyc);
        end
    endtask

    initial begin
        longint n, phi, dm, e;
        int cur_p = -1;
        int cur_q = -1;

        bus.p = '0; bus.q = '0; bus.reset_inverter = 1'b0; bus.reset_mod_exp = 1'b0;
        bus.encrypt_decrypt = 1'b0; bus.msg_in = '0;

        vt[0] = '{61, 53, 1'b0, 65, 2790};
        vt[1] = '{61, 53, 1'b1, 2790, 65};
        vt[2] = '{3, 11, 1'b0, 7, 28};
        vt[3] = '{3, 11, 1'b1, 28, 7};
        vt[4] = '{251, 241, 1'b0, 12345, -1};
        vt[5] = '{251, 241, 1'b1, int'(modpow(12345, 65537, 60491)), 12345};
        vt[6] = '{13, 17, 1'b0, 60000, -1};
        vt[7] = '{1, 7, 1'b1, 5, 1};
        vt[8] = '{1, 7, 1'b0, 3, 5};
        vt[9] = '{1, 1, 1'b0, 9, 0};

        repeat (3) @(negedge clk);
        check("reset_inverter_finish", longint'(bus.inverter_finish), 0);
        check("reset_mod_exp_finish", longint'(bus.mod_exp_finish), 0);
        check("reset_msg_out", longint'(bus.msg_out), 0);
        reset_n = 1'b1;

        // Exponentiation strobe without keys must be ignored.
        pulse_exp(1'b0, 5);
        repeat (60) @(negedge clk);
        check("early_mod_exp_ignored", longint'(bus.mod_exp_finish), 0);

        for (int i = 0; i < 10; i++) begin
            n   = longint'(vt[i].p) * vt[i].q;
            phi = longint'(vt[i].p - 1) * (vt[i].q - 1);
            dm  = modinv(phi);
            if (vt[i].p != cur_p || vt[i].q != cur_q) begin
                pulse_inv(vt[i].p, vt[i].q);
                wait_flag(1'b0, "inverter_finish");
                check("d", longint'(dut.d), dm);
                cur_p = vt[i].p;
                cur_q = vt[i].q;
            end
            e = vt[i].ed ? dm : 65537;
            sb_q.push_back((vt[i].exp >= 0) ? longint'(vt[i].exp) : modpow(vt[i].msg, e, n));
            pulse_exp(vt[i].ed, vt[i].msg);
            wait_flag(1'b1, "mod_exp_finish");
        end
        @(negedge clk);
        check("scoreboard_drained", longint'(sb_q.size()), 0);

        // Both strobes together: key derivation restarts, exponentiation does not run.
        @(negedge clk);
        bus.p = W'(61); bus.q = W'(53); bus.msg_in = NW'(65);
        bus.reset_inverter = 1'b1; bus.reset_mod_exp = 1'b1;
        @(negedge clk);
        bus.reset_inverter = 1'b0; bus.reset_mod_exp = 1'b0;
        check("both_strobes_inv_flag", longint'(bus.inverter_finish), 0);
        check("both_strobes_exp_flag", longint'(bus.mod_exp_finish), 0);
        wait_flag(1'b0, "inverter_finish_both");
        repeat (400) @(negedge clk);
        check("both_strobes_no_exp", longint'(bus.mod_exp_finish), 0);

        // Abort a decrypt mid-loop with a new key derivation.
        pulse_inv(251, 241);
        wait_flag(1'b0, "inverter_finish_abort_key");
        pulse_exp(1'b1, 777);
        repeat (40) @(negedge clk);
        check("exp_running_flag", longint'(bus.mod_exp_finish), 0);
        pulse_inv(61, 53);
        check("abort_inv_flag", longint'(bus.inverter_finish), 0);
        check("abort_exp_flag", longint'(bus.mod_exp_finish), 0);
        wait_flag(1'b0, "inverter_finish_after_abort");
        check("d_after_abort", longint'(dut.d), 2753);
        sb_q.push_back(65);
        pulse_exp(1'b1, 2790);
        wait_flag(1'b1, "mod_exp_finish_after_abort");
        bus.msg_in = NW'(1234);
        repeat (20) @(negedge clk);
        check("msg_out_hold", longint'(bus.msg_out), 65);

        // Asynchronous reset in the middle of key derivation.
        pulse_inv(3, 11);
        repeat (10) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midreset_inv_flag", longint'(bus.inverter_finish), 0);
        check("midreset_exp_flag", longint'(bus.mod_exp_finish), 0);
        check("midreset_msg_out", longint'(bus.msg_out), 0);
        check("midreset_d", longint'(dut.d), 0);
        @(negedge clk);
        reset_n = 1'b1;
        pulse_inv(3, 11);
        wait_flag(1'b0, "inverter_finish_after_reset");
        check("d_after_reset", longint'(dut.d), 13);
        sb_q.push_back(28);
        pulse_exp(1'b0, 7);
        wait_flag(1'b1, "mod_exp_finish_after_reset");
        repeat (2) @(negedge clk);
        check("final_scoreboard_drained", longint'(sb_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rsa_control.md
# rsa_control

Iterative RSA key-derivation and modular-exponentiation engine. Given primes p and q, it derives modulus n = p·q and totient φ = (p−1)(q−1). It computes the private exponent d = e⁻¹ mod φ for the fixed public exponent e = 65537. It then encrypts (msg^e mod n) or decrypts (msg^d mod n) one message per run. It is a leaf block driven by an external sequencer through two start strobes and two finish flags.

## Interface
- WIDTH, default 128: prime width; modulus, messages and exponents are 2·WIDTH bits.
- clk  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low global reset.
- p  in  WIDTH  prime p (unsigned).
- q  in  WIDTH  prime q (unsigned).
- reset_inverter  in  1  active-high start strobe for key derivation; sampled on clk.
- reset_mod_exp  in  1  active-high start strobe for exponentiation; sampled on clk.
- encrypt_decrypt  in  1  0 = encrypt (exponent e), 1 = decrypt (exponent d).
- msg_in  in  2·WIDTH  message.
- inverter_finish  out  1  d valid; level, held until next reset_inverter.
- msg_out  out  2·WIDTH  result; held until next exponentiation completes.
- mod_exp_finish  out  1  msg_out valid; level, held until next start.

## Operation
- Reset (reset_n=0): FSM to IDLE, inverter_finish=0, mod_exp_finish=0, msg_out=0, internal n/φ/d cleared.
- States: IDLE → INV_SETUP → INV_LOOP → INV_DONE → EXP_SETUP → EXP_LOOP → EXP_DONE.
- reset_inverter=1 at any edge, from any state, aborts current work:
  - Clears both finish flags.
  - Latches p, q; computes n = p·q (2·WIDTH bits exact) and φ = (p−1)(q−1).
  - Enters INV_LOOP.
- INV_LOOP: extended Euclid on (φ, e mod φ), one division step per cycle (restoring shift-subtract division allowed, multi-cycle).
  - Result d in [1, φ−1] with e·d ≡ 1 mod φ.
  - If gcd(e, φ) ≠ 1, d = 0.
  - Then INV_DONE: inverter_finish=1.
- reset_mod_exp=1 while inverter_finish=1:
  - Clears mod_exp_finish.
  - Latches msg_in and encrypt_decrypt.
  - Selects exponent k = 65537 (encrypt) or d (decrypt).
  - Reduces m = msg_in mod n.
- reset_mod_exp while inverter_finish=0 is ignored.
- EXP_LOOP: left-to-right square-and-multiply over 2·WIDTH exponent bits (leading zeros may be skipped).
  - Each modular multiply uses interleaved shift-add reduction mod n, one bit per cycle.
  - Intermediates are never wider than 2·WIDTH+2 bits.
- Result = m^k mod n (k=0 → 1 mod n; n=1 → 0). Written to msg_out; mod_exp_finish=1; back to idle-wait with flags held.
- Two instances with identical p, q: decrypt(encrypt(x)) = x for every x < n with gcd(e, φ)=1.
- Simultaneous reset_inverter and reset_mod_exp: reset_inverter wins; reset_mod_exp is ignored.

## Timing
- Strobes are one clk cycle wide; they are acted on at the first rising edge where high.
- Finish flags rise on a clock edge, never combinationally.
- The sequencer polls each flag at posedge and may strobe reset_mod_exp on the following cycle.
- Key-derivation latency:
  - Bounded by O(WIDTH) Euclid steps × O(WIDTH) cycles per division.
  - Must be < 64·WIDTH² cycles.
- Exponentiation latency:
  - ≤ 2·(2·WIDTH) modular multiplies × (2·WIDTH+2) cycles, plus the initial reduction.
  - Encrypt uses 17 multiplies.
- msg_out changes only in the cycle mod_exp_finish rises.
- Inputs p, q, msg_in and encrypt_decrypt may change freely after being latched.
- reset_n asserted mid-operation: immediate return to reset values; no finish flag is produced.

## Test plan
- WIDTH=8, p=61, q=53, encrypt, msg_in=65 → d=2753 (internal), inverter_finish=1, msg_out=2790, mod_exp_finish=1.
- Same keys, decrypt, msg_in=2790 → msg_out=65.
- WIDTH=8, p=3, q=11, encrypt msg_in=7 → msg_out=28; decrypt 28 → msg_out=7 (d=13).
- WIDTH=128, p=8475698667747010771, q=11297384090418420749: encrypt 0x9d in instance A, decrypt A's msg_out in instance B → B msg_out=0x9d; repeat for msg_in=0x7b00000000000 and 0x1a9c2dc611.
- Strobe reset_mod_exp before inverter_finish is high → ignored, mod_exp_finish stays 0. Strobe reset_inverter during EXP_LOOP → both flags drop and a new run completes correctly.
- reset_n pulse low mid-INV_LOOP → all outputs 0 immediately; a fresh start afterwards yields correct results.
